// File: rtl/fetch_pkg.sv
// fetch_pkg: shared definitions for the instruction fetch unit.
//   - state_t            : fetch controller states (IDLE, FETCH, WAIT_DEC, HALTED)
//   - FETCH_ADDR_W       : default memory address width
//   - FETCH_DATA_W       : default instruction word width
//   - FETCH_RESET_PC     : default PC loaded on reset
package fetch_pkg;

  localparam int FETCH_ADDR_W = 12;
  localparam int FETCH_DATA_W = 16;
  localparam logic [FETCH_ADDR_W-1:0] FETCH_RESET_PC = 12'h000;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_FETCH    = 2'd1,
    ST_WAIT_DEC = 2'd2,
    ST_HALTED   = 2'd3
  } state_t;

endpackage

// File: rtl/fetch_skid.sv
// fetch_skid: one-entry prefetch buffer holding a fetched word and the
// address it came from.
//   clk, rst     : clock, synchronous active-high reset
//   load         : capture wr_data/wr_pc, entry becomes full
//   pop          : release the entry (ignored when load is also high,
//                  since load replaces the consumed word in the same cycle)
//   flush        : discard the entry (highest priority after rst)
//   wr_data      : word to store
//   wr_pc        : address the word was fetched from
//   entry_data   : stored word
//   entry_pc     : stored address
//   full         : entry holds a word
module fetch_skid
  import fetch_pkg::*;
#(
  parameter int ADDR_W = FETCH_ADDR_W,
  parameter int DATA_W = FETCH_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              pop,
  input  logic              flush,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [ADDR_W-1:0] wr_pc,
  output logic [DATA_W-1:0] entry_data,
  output logic [ADDR_W-1:0] entry_pc,
  output logic              full
);

  always_ff @(posedge clk) begin
    if (rst) begin
      full       <= 1'b0;
      entry_data <= '0;
      entry_pc   <= '0;
    end else if (flush) begin
      full <= 1'b0;
    end else if (load) begin
      full       <= 1'b1;
      entry_data <= wr_data;
      entry_pc   <= wr_pc;
    end else if (pop) begin
      full <= 1'b0;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: sequential instruction fetch unit feeding a decode stage.
// Optional feature macro: FETCH_PREFETCH_EN (one-entry prefetch buffer,
// sustains one instruction per cycle). Without it, one instruction per two
// cycles.
//
// Ports:
//   clk        in  : clock, rising edge
//   rst        in  : synchronous active-high reset
//   start      in  : leave IDLE and begin fetching
//   halt       in  : stop fetching until reset
//   jump_en    in  : redirect PC this cycle
//   jump_addr  in  : redirect target
//   Read       out : memory read strobe (data returns in the same cycle)
//   address    out : memory address, always equal to pc
//   data_in    in  : memory read data
//   ir         out : fetched instruction
//   ir_pc      out : address ir was fetched from
//   ir_valid   out : ir holds an unconsumed instruction
//   ir_ready   in  : decode accepts ir this cycle
//   pc         out : next fetch address
//   busy       out : high in FETCH or WAIT_DEC
//   state      out : current controller state (debug)
//
// Handshake: an instruction transfers to decode on a rising edge where
// ir_valid && ir_ready are both high; ir/ir_pc are stable while ir_valid is
// high and ir_ready is low. jump_en and halt cancel any pending transfer.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int ADDR_W = FETCH_ADDR_W,
  parameter int DATA_W = FETCH_DATA_W,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(FETCH_RESET_PC)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              halt,
  input  logic              jump_en,
  input  logic [ADDR_W-1:0] jump_addr,
  output logic              Read,
  output logic [ADDR_W-1:0] address,
  input  logic [DATA_W-1:0] data_in,
  output logic [DATA_W-1:0] ir,
  output logic [ADDR_W-1:0] ir_pc,
  output logic              ir_valid,
  input  logic              ir_ready,
  output logic [ADDR_W-1:0] pc,
  output logic              busy,
  output state_t            state
);

  state_t state_r;
  state_t state_nxt;

  logic              read_en;
  logic              accept;
  logic              halting;
  logic [ADDR_W-1:0] pc_r;
  logic [DATA_W-1:0] ir_r;
  logic [ADDR_W-1:0] ir_pc_r;
  logic              ir_valid_r;

  // Decode takes the current instruction at this edge.
  assign accept  = (state_r == ST_WAIT_DEC) && ir_valid_r && ir_ready;
  // halt acts in every state except HALTED and beats jump_en/start.
  assign halting = halt && (state_r != ST_HALTED);

`ifdef FETCH_PREFETCH_EN
  logic              buf_full;
  logic [DATA_W-1:0] buf_data;
  logic [ADDR_W-1:0] buf_pc;
  logic              buf_load;
  logic              buf_pop;
  logic              buf_flush;
  logic              in_wait;

  assign in_wait   = (state_r == ST_WAIT_DEC);
  // When the buffer is empty and decode accepts in the same cycle, the word
  // read this cycle goes straight into ir instead of through the buffer.
  assign buf_load  = in_wait && read_en && !jump_en && (buf_full || !accept);
  assign buf_pop   = in_wait && accept && buf_full && !jump_en;
  assign buf_flush = halting ||
                     (jump_en && (state_r == ST_FETCH || state_r == ST_WAIT_DEC));

  fetch_skid #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W)
  ) u_skid (
    .clk        (clk),
    .rst        (rst),
    .load       (buf_load),
    .pop        (buf_pop),
    .flush      (buf_flush),
    .wr_data    (data_in),
    .wr_pc      (pc_r),
    .entry_data (buf_data),
    .entry_pc   (buf_pc),
    .full       (buf_full)
  );
`endif

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state_r;
    if (halting) begin
      state_nxt = ST_HALTED;
    end else begin
      case (state_r)
        ST_IDLE: begin
          // A jump in IDLE only reloads pc; it wins over start.
          if (start && !jump_en) state_nxt = ST_FETCH;
        end
        ST_FETCH: begin
          state_nxt = jump_en ? ST_FETCH : ST_WAIT_DEC;
        end
        ST_WAIT_DEC: begin
          if (jump_en) begin
            state_nxt = ST_FETCH;
          end else if (accept) begin
`ifdef FETCH_PREFETCH_EN
            // ir is refilled from the buffer or the concurrent read.
            state_nxt = ST_WAIT_DEC;
`else
            state_nxt = ST_FETCH;
`endif
          end
        end
        ST_HALTED: state_nxt = ST_HALTED;
        default:   state_nxt = ST_IDLE;
      endcase
    end
  end

  // Output logic
  always_comb begin
    read_en = 1'b0;
    busy    = 1'b0;
    case (state_r)
      ST_FETCH: begin
        read_en = !halt;
        busy    = 1'b1;
      end
      ST_WAIT_DEC: begin
`ifdef FETCH_PREFETCH_EN
        // Read when the buffer has room, or when it is being drained now.
        read_en = !halt && (!buf_full || ir_ready);
`else
        read_en = 1'b0;
`endif
        busy    = 1'b1;
      end
      default: begin
        read_en = 1'b0;
        busy    = 1'b0;
      end
    endcase
  end

  // Datapath: pc, ir, ir_pc, ir_valid
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_r       <= RESET_PC;
      ir_r       <= '0;
      ir_pc_r    <= '0;
      ir_valid_r <= 1'b0;
    end else if (halting) begin
      ir_valid_r <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (jump_en) pc_r <= jump_addr;
        end
        ST_FETCH: begin
          if (jump_en) begin
            pc_r       <= jump_addr;
            ir_valid_r <= 1'b0;
          end else begin
            ir_r       <= data_in;
            ir_pc_r    <= pc_r;
            pc_r       <= pc_r + ADDR_W'(1);
            ir_valid_r <= 1'b1;
          end
        end
        ST_WAIT_DEC: begin
          if (jump_en) begin
            pc_r       <= jump_addr;
            ir_valid_r <= 1'b0;
          end else begin
`ifdef FETCH_PREFETCH_EN
            if (read_en) pc_r <= pc_r + ADDR_W'(1);
            if (accept) begin
              if (buf_full) begin
                ir_r    <= buf_data;
                ir_pc_r <= buf_pc;
              end else begin
                ir_r    <= data_in;
                ir_pc_r <= pc_r;
              end
            end
`else
            if (accept) ir_valid_r <= 1'b0;
`endif
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign Read     = read_en;
  assign address  = pc_r;
  assign pc       = pc_r;
  assign ir       = ir_r;
  assign ir_pc    = ir_pc_r;
  assign ir_valid = ir_valid_r;
  assign state    = state_r;

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: self-checking bench for fetch_unit. Directed scenarios with
// cycle-exact expectations plus a randomized run checked against an
// instruction-stream model (expected next address + memory image).
// Build with FETCH_PREFETCH_EN defined to exercise the prefetch variant.
module tb_fetch_unit;
  import fetch_pkg::*;

  localparam int AW = 12;
  localparam int DW = 16;
`ifdef FETCH_PREFETCH_EN
  localparam bit PREF = 1'b1;
`else
  localparam bit PREF = 1'b0;
`endif
  // Cycles between successive instructions with ir_ready held high.
  localparam int GAP = PREF ? 1 : 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          halt;
  logic          jump_en;
  logic [AW-1:0] jump_addr;
  logic          read;
  logic [AW-1:0] address;
  logic [DW-1:0] data_in;
  logic [DW-1:0] ir;
  logic [AW-1:0] ir_pc;
  logic          ir_valid;
  logic          ir_ready;
  logic [AW-1:0] pc;
  logic          busy;
  state_t        state;

  logic [DW-1:0] mem [0:(1<<AW)-1];
  logic [DW-1:0] words [0:3];

  int checks = 0;
  int errors = 0;

  assign data_in = mem[address];

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  fetch_unit dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .halt      (halt),
    .jump_en   (jump_en),
    .jump_addr (jump_addr),
    .Read      (read),
    .address   (address),
    .data_in   (data_in),
    .ir        (ir),
    .ir_pc     (ir_pc),
    .ir_valid  (ir_valid),
    .ir_ready  (ir_ready),
    .pc        (pc),
    .busy      (busy),
    .state     (state)
  );

  // ---------------- scoreboard ----------------
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; start = 1'b0; halt = 1'b0; jump_en = 1'b0;
    jump_addr = '0; ir_ready = 1'b0;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  // Expected stream of instructions: the next address decode should see.
  logic [AW-1:0] exp_addr;
  logic [AW-1:0] exp_q[$];
  int            taken;
  int            rd_cnt;

  initial begin
    words[0] = 16'h3002; words[1] = 16'h1003;
    words[2] = 16'h0007; words[3] = 16'h0005;
    for (int i = 0; i < (1<<AW); i++) mem[i] = DW'($urandom);
    for (int i = 0; i < 4; i++) mem[i] = words[i];

    // ---- reset state ----
    do_reset();
    settle();
    check("rst_state", 32'(state), 32'(ST_IDLE));
    check("rst_pc", 32'(pc), 32'h000);
    check("rst_ir", 32'(ir), 32'h0);
    check("rst_ir_pc", 32'(ir_pc), 32'h0);
    check("rst_valid", 32'(ir_valid), 32'h0);
    check("rst_read", 32'(read), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);

    // ---- sequential stream, decode always ready ----
    ir_ready = 1'b1;
    do_start();
    settle();
    check("seq_fetch_read", 32'(read), 32'h1);
    check("seq_fetch_addr", 32'(address), 32'h000);
    check("seq_fetch_busy", 32'(busy), 32'h1);
    step();
    for (int k = 0; k < 4; k++) begin
      check("seq_ir", 32'(ir), 32'(words[k]));
      check("seq_ir_pc", 32'(ir_pc), 32'(k));
      check("seq_valid", 32'(ir_valid), 32'h1);
      if (k < 3) repeat (GAP) step();
    end

    // ---- decode stalls for 5 cycles ----
    do_reset();
    do_start();
    step();
    rd_cnt = 0;
    for (int c = 0; c < 5; c++) begin
      settle();
      if (read) rd_cnt++;
      step();
    end
    check("stall_ir", 32'(ir), 32'h3002);
    check("stall_ir_pc", 32'(ir_pc), 32'h0);
    check("stall_valid", 32'(ir_valid), 32'h1);
    check("stall_reads", 32'(rd_cnt), PREF ? 32'd1 : 32'd0);
    check("stall_pc", 32'(pc), PREF ? 32'h2 : 32'h1);

    // ---- jump during WAIT_DEC ----
    do_reset();
    do_start();
    step();
    jump_en = 1'b1; jump_addr = 12'h003;
    step();
    jump_en = 1'b0;
    check("jmp_valid", 32'(ir_valid), 32'h0);
    check("jmp_pc", 32'(pc), 32'h003);
    settle();
    check("jmp_read", 32'(read), 32'h1);
    check("jmp_addr", 32'(address), 32'h003);
    step();
    check("jmp_ir", 32'(ir), 32'h0005);
    check("jmp_ir_pc", 32'(ir_pc), 32'h003);
    check("jmp_ir_valid", 32'(ir_valid), 32'h1);

    // ---- jump in IDLE (beats start), then wrap at top of memory ----
    do_reset();
    ir_ready = 1'b1;
    jump_en = 1'b1; jump_addr = 12'hFFF; start = 1'b1;
    step();
    jump_en = 1'b0; start = 1'b0;
    check("idle_jmp_pc", 32'(pc), 32'hFFF);
    check("idle_jmp_state", 32'(state), 32'(ST_IDLE));
    do_start();
    step();
    check("wrap_ir_pc0", 32'(ir_pc), 32'hFFF);
    check("wrap_ir0", 32'(ir), 32'(mem[12'hFFF]));
    check("wrap_pc", 32'(pc), 32'h000);
    repeat (GAP) step();
    check("wrap_ir_pc1", 32'(ir_pc), 32'h000);
    check("wrap_ir1", 32'(ir), 32'h3002);

    // ---- halt together with jump ----
    do_reset();
    do_start();
    step();
    halt = 1'b1; jump_en = 1'b1; jump_addr = 12'h555;
    settle();
    check("halt_read_now", 32'(read), 32'h0);
    step();
    halt = 1'b0; jump_en = 1'b0;
    settle();
    check("halt_state", 32'(state), 32'(ST_HALTED));
    check("halt_read", 32'(read), 32'h0);
    check("halt_valid", 32'(ir_valid), 32'h0);
    check("halt_pc", 32'(pc), 32'h001);
    check("halt_busy", 32'(busy), 32'h0);
    do_start();
    step();
    settle();
    check("halt_start_state", 32'(state), 32'(ST_HALTED));
    check("halt_start_read", 32'(read), 32'h0);
    check("halt_start_pc", 32'(pc), 32'h001);
    do_reset();
    check("halt_rst_state", 32'(state), 32'(ST_IDLE));
    check("halt_rst_pc", 32'(pc), 32'h000);

    // ---- reset while in FETCH ----
    do_reset();
    do_start();
    rst = 1'b1;
    step();
    rst = 1'b0;
    settle();
    check("rstf_valid", 32'(ir_valid), 32'h0);
    check("rstf_read", 32'(read), 32'h0);
    check("rstf_pc", 32'(pc), 32'h000);
    check("rstf_state", 32'(state), 32'(ST_IDLE));

    // ---- randomized run against the instruction-stream model ----
    do_reset();
    do_start();
    exp_addr = '0;
    taken = 0;
    for (int cyc = 0; cyc < 800; cyc++) begin
      ir_ready  = 1'($urandom_range(0, 1));
      jump_en   = ($urandom_range(0, 15) == 0);
      jump_addr = AW'($urandom);
      settle();
      check("rnd_addr_eq_pc", 32'(address), 32'(pc));
      if (!busy) check("rnd_read_idle", 32'(read), 32'h0);
      if (ir_valid) begin
        check("rnd_ir_pc", 32'(ir_pc), 32'(exp_addr));
        check("rnd_ir", 32'(ir), 32'(mem[exp_addr]));
      end
      if (jump_en) begin
        exp_addr = jump_addr;
      end else if (ir_valid && ir_ready) begin
        exp_q.push_back(exp_addr);
        exp_addr = exp_addr + AW'(1);
        taken++;
      end
      step();
    end
    jump_en = 1'b0;
    ir_ready = 1'b0;
    // About 1/2 readiness gives far more than this many transfers in either build.
    check("rnd_progress", 32'(taken >= 100), 32'h1);
    check("rnd_q_size", 32'(exp_q.size()), 32'(taken));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Bound on total simulation time.
  initial begin
    #500000;
    errors++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL provide parameter RESET_PC, default 12'h000, PC value loaded on reset.
REQ-002 SHALL provide parameter ADDR_W, default 12, memory address width.
REQ-003 SHALL provide parameter DATA_W, default 16, instruction word width.
REQ-004 SHALL have ports (name direction width meaning):
- clk in 1: single clock, rising edge.
- rst in 1: reset, synchronous, active-high.
- start in 1: leave IDLE and begin fetching.
- halt in 1: stop fetching permanently until reset.
- jump_en in 1: redirect PC this cycle.
- jump_addr in ADDR_W: redirect target.
- Read out 1: memory read strobe; memory returns data combinationally in the same cycle.
- address out ADDR_W: memory address.
- data_in in DATA_W: memory read data.
- ir out DATA_W: fetched instruction to decode.
- ir_pc out ADDR_W: address the current ir was fetched from.
- ir_valid out 1: ir holds an unconsumed instruction.
- ir_ready in 1: decode accepts ir this cycle.
- pc out ADDR_W: next fetch address.
- busy out 1: high in FETCH or WAIT_DEC.

Function
REQ-005 SHALL implement states IDLE, FETCH, WAIT_DEC, HALTED.
REQ-006 IDLE: Read=0; start=1 SHALL move to FETCH next edge.
REQ-007 FETCH: Read=1, address=pc; at edge SHALL load ir<=data_in, ir_pc<=pc, pc<=pc+1, ir_valid<=1, go to WAIT_DEC.
REQ-008 WAIT_DEC: Read=0; ir and ir_pc SHALL be held stable; ir_valid&&ir_ready at edge SHALL clear ir_valid and go to FETCH.
REQ-009 Throughput without prefetch SHALL be one instruction per two cycles; fetch-to-ir_valid latency one cycle.
REQ-010 pc increment SHALL wrap modulo 2^ADDR_W (12'hFFF -> 12'h000).
REQ-011 address SHALL equal pc at all times; Read SHALL be 0 outside FETCH (and outside prefetch fetches when REQ-017 applies).
REQ-012 jump_en in FETCH or WAIT_DEC SHALL set pc<=jump_addr, clear ir_valid, discard the in-flight word, next state FETCH; jump_en overrides a simultaneous ir_ready/start handshake.
REQ-013 jump_en in IDLE SHALL load pc<=jump_addr and stay in IDLE; ignored in HALTED.
REQ-014 halt in any state except HALTED SHALL clear ir_valid, force Read=0, and go to HALTED; halt beats jump_en and start; HALTED exits only via rst.
REQ-015 Block SHALL never write memory.

Reset
REQ-016 rst SHALL, at the next edge and regardless of state, set state=IDLE, pc=RESET_PC, ir=0, ir_pc=0, ir_valid=0, prefetch buffer empty; Read=0 and busy=0 while in IDLE; rst overrides all other inputs.

Configuration
REQ-017 With FETCH_PREFETCH_EN defined: one-entry prefetch buffer; in WAIT_DEC with buffer empty SHALL assert Read, store data_in and pc into buffer, pc<=pc+1; on handshake with buffer full SHALL move buffer into ir, keep ir_valid=1, and refill in the same cycle, sustaining one instruction per cycle; jump_en and halt SHALL flush the buffer.
REQ-018 Without FETCH_PREFETCH_EN: no buffer logic; behaviour exactly REQ-005..REQ-014.

Structure
REQ-019 Package fetch_pkg SHALL hold the state enum, ADDR_W/DATA_W defaults and RESET_PC default.
REQ-020 Prefetch entry SHALL be sub-module fetch_skid (data+pc register, full flag, load/pop/flush), instantiated only under FETCH_PREFETCH_EN.

Verification
REQ-021 Memory words 0..3 = 16'h3002,16'h1003,16'h0007,16'h0005, ir_ready=1, pulse start -> ir sequence 3002,1003,0007,0005 with ir_pc 0..3, one per 2 cycles (per cycle with macro).
REQ-022 ir_ready=0 for 5 cycles after first fetch -> ir=16'h3002 held, Read=0 (one prefetch read with macro), pc=1 (2 with macro).
REQ-023 jump_en with jump_addr=12'h003 during WAIT_DEC -> ir_valid low next cycle, next ir=16'h0005, ir_pc=3.
REQ-024 jump_addr=12'hFFF then two fetches -> ir_pc 12'hFFF then 12'h000.
REQ-025 halt and jump_en same cycle -> HALTED, Read=0, ir_valid=0, pc unchanged; later start ignored; rst -> pc=RESET_PC, IDLE.
REQ-026 rst asserted in FETCH -> next cycle ir_valid=0, Read=0, pc=12'h000.
